calc_op_sequencer: RTL



---
 rtl/calc_op_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: gathers operands A/B and an operator, starts the ALU,
// waits for done under a watchdog. Optional macro CALC_CHAIN_EN reuses the result as operand A.
module calc_op_sequencer #(
  parameter int WIDTH   = 40,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter_pulse,
  input  logic             clear_pulse,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] in_val,
  input  logic             alu_done,
  input  logic             alu_err,
  input  logic             alu_sign,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] result,
  output logic             sign,
  output logic             error,
  output logic [1:0]       display_sel,
  output logic [9:0]       led
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] DISP_A      = 2'b00;
  localparam logic [1:0] DISP_B      = 2'b01;
  localparam logic [1:0] DISP_ERR    = 2'b10;
  localparam logic [1:0] DISP_RESULT = 2'b11;
  localparam logic [1:0] OP_DIV      = 2'b11;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_START,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic [WIDTH-1:0] s1_reg, s1_next;
  logic [WIDTH-1:0] s2_reg, s2_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             sign_reg, sign_next;
  logic             error_reg, error_next;
  logic [1:0]       op_reg, op_next;
  logic [1:0]       disp_reg, disp_next;
  logic             wd_reg, wd_next;
  logic             start_reg, start_next;
  logic [9:0]       led_reg, led_next;
  logic             done_clear;

  assign cnt_inc = cnt_reg + CW'(1);

  // Enter in DONE either chains the result or acts as a full clear.
`ifdef CALC_CHAIN_EN
  assign done_clear = 1'b0;
`else
  assign done_clear = (state_reg == ST_DONE) && enter_pulse;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    s1_next     = s1_reg;
    s2_next     = s2_reg;
    result_next = result_reg;
    sign_next   = sign_reg;
    error_next  = error_reg;
    op_next     = op_reg;
    disp_next   = disp_reg;
    wd_next     = wd_reg;

    if (clear_pulse || done_clear) begin
      state_next  = ST_ENTER_A;
      cnt_next    = '0;
      s1_next     = '0;
      s2_next     = '0;
      result_next = '0;
      sign_next   = 1'b0;
      error_next  = 1'b0;
      op_next     = 2'b00;
      disp_next   = DISP_A;
      wd_next     = 1'b0;
    end else begin
      case (state_reg)
        ST_ENTER_A: begin
          if (enter_pulse) begin
            s1_next    = in_val;
            disp_next  = DISP_B;
            state_next = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (enter_pulse) begin
            s2_next = in_val;
            op_next = op_sel;
            // Divide-by-zero is caught here so the ALU is never started.
            if (op_sel == OP_DIV && in_val == '0) begin
              error_next = 1'b1;
              disp_next  = DISP_ERR;
              state_next = ST_ERROR;
            end else begin
              state_next = ST_START;
            end
          end
        end
        ST_START: begin
          cnt_next   = '0;
          state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_done) begin
            if (alu_err) begin
              error_next = 1'b1;
              disp_next  = DISP_ERR;
              state_next = ST_ERROR;
            end else begin
              result_next = alu_result;
              sign_next   = alu_sign;
              disp_next   = DISP_RESULT;
              state_next  = ST_DONE;
            end
          end else if (cnt_inc == CW'(TIMEOUT)) begin
            wd_next    = 1'b1;
            error_next = 1'b1;
            disp_next  = DISP_ERR;
            state_next = ST_ERROR;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        ST_DONE: begin
`ifdef CALC_CHAIN_EN
          if (enter_pulse) begin
            s1_next    = result_reg;
            s2_next    = '0;
            error_next = 1'b0;
            sign_next  = 1'b0;
            disp_next  = DISP_B;
            state_next = ST_ENTER_B;
          end
`endif
        end
        ST_ERROR: begin
          state_next = ST_ERROR;
        end
        default: begin
          state_next = ST_ENTER_A;
        end
      endcase
    end
  end

  // Status outputs are registered from the next-state view so they line up with state.
  always_comb begin
    start_next  = (state_next == ST_START);
    led_next    = '0;
    led_next[0] = (state_next != ST_ENTER_A);
    led_next[1] = (state_next == ST_START) || (state_next == ST_WAIT);
    led_next[2] = (state_next == ST_DONE);
    led_next[3] = (state_next == ST_ERROR);
    led_next[4] = wd_next;
    led_next[9:8] = op_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_ENTER_A;
      cnt_reg    <= '0;
      s1_reg     <= '0;
      s2_reg     <= '0;
      result_reg <= '0;
      sign_reg   <= 1'b0;
      error_reg  <= 1'b0;
      op_reg     <= 2'b00;
      disp_reg   <= DISP_A;
      wd_reg     <= 1'b0;
      start_reg  <= 1'b0;
      led_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      s1_reg     <= s1_next;
      s2_reg     <= s2_next;
      result_reg <= result_next;
      sign_reg   <= sign_next;
      error_reg  <= error_next;
      op_reg     <= op_next;
      disp_reg   <= disp_next;
      wd_reg     <= wd_next;
      start_reg  <= start_next;
      led_reg    <= led_next;
    end
  end

  assign alu_start   = start_reg;
  assign alu_op      = op_reg;
  assign s1          = s1_reg;
  assign s2          = s2_reg;
  assign result      = result_reg;
  assign sign        = sign_reg;
  assign error       = error_reg;
  assign display_sel = disp_reg;
  assign led         = led_reg;

endmodule
